// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store read-modify-write unit:
// FSM state encoding, access-size codes and the byte-lane mask helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Byte lanes touched by an access of the given size at the given offset.
  // The offset is assumed already aligned for the size.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_B:    m = 4'b0001 << offset;
      SZ_H:    m = offset[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: merges store data into an old word and
// extracts/extends load data from a little-endian word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [3:0]  mask;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign mask = lane_mask(size, offset);

  // Each lane either keeps the old byte or takes the matching byte of the
  // right-justified store data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] src;
      // Pick which store-data byte would land in this lane.
      always_comb begin
        case (size)
          SZ_B:    src = wdata[7:0];
          SZ_H:    src = wdata[8*(gi%2) +: 8];
          default: src = wdata[8*gi +: 8];
        endcase
      end
      assign merged[8*gi +: 8] = mask[gi] ? src : old_word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rd_word[{offset, 3'b000} +: 8];
  assign half_sel = rd_word[{offset[1], 4'b0000} +: 16];

  // Right-justify the selected lane and extend it; words pass through.
  always_comb begin
    case (size)
      SZ_B:    load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store initiator: turns byte/half/word core requests into word-wide
// memory accesses, doing read-modify-write for sub-word stores.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W            = 16,
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              write_reg;
  logic              unsigned_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       word_reg;
  logic [31:0]       rdata_reg;
  logic              fault_reg;

  logic              illegal;
  logic              misaligned;
  logic              bad_req;
  logic [ADDR_W-1:0] aligned_addr;
  logic [31:0]       merged;
  logic [31:0]       load_data;

  assign illegal    = (req_size == 2'b11);
  assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign bad_req    = illegal || (FAULT_ON_MISALIGN && misaligned);

  // Clear the offending low address bits; only matters when misalignment
  // does not fault, since faulting requests never touch memory.
  always_comb begin
    aligned_addr = req_addr;
    if (req_size == SZ_H) aligned_addr[0] = 1'b0;
    if (req_size == SZ_W) aligned_addr[1:0] = 2'b00;
  end

  lsu_lane u_lane (
    .old_word   (word_reg),
    .wdata      (wdata_reg),
    .size       (size_reg),
    .offset     (addr_reg[1:0]),
    .rd_word    (mem_rd),
    .is_unsigned(unsigned_reg),
    .merged     (merged),
    .load_data  (load_data)
  );

  // Access sequencer: IDLE -> [READ] -> [WRITE] -> RESP -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      size_reg     <= 2'b00;
      write_reg    <= 1'b0;
      unsigned_reg <= 1'b0;
      wdata_reg    <= '0;
      word_reg     <= '0;
      rdata_reg    <= '0;
      fault_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            addr_reg     <= aligned_addr;
            size_reg     <= req_size;
            write_reg    <= req_write;
            unsigned_reg <= req_unsigned;
            wdata_reg    <= req_wdata;
            rdata_reg    <= '0;
            fault_reg    <= 1'b0;
            if (bad_req) begin
              fault_reg <= 1'b1;
              state_reg <= ST_RESP;
            end else if (req_write && (req_size == SZ_W)) begin
              state_reg <= ST_WRITE;
            end else begin
              state_reg <= ST_READ;
            end
          end
        end
        ST_READ: begin
          word_reg <= mem_rd;
          if (write_reg) begin
            state_reg <= ST_WRITE;
          end else begin
            rdata_reg <= load_data;
            state_reg <= ST_RESP;
          end
        end
        ST_WRITE: begin
          state_reg <= ST_RESP;
        end
        default: begin
          rdata_reg <= '0;
          fault_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_reg == ST_IDLE);
  assign resp_valid  = (state_reg == ST_RESP);
  assign resp_rdata  = rdata_reg;
  assign resp_fault  = fault_reg;
  // Reset gates the strobe immediately so a write in flight is dropped.
  assign mem_we      = (state_reg == ST_WRITE) && rst_n;
  assign mem_address = ((state_reg == ST_READ) || (state_reg == ST_WRITE)) ?
                       {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wd      = (state_reg == ST_WRITE) ?
                       ((size_reg == SZ_W) ? wdata_reg : merged) : '0;

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: two instances (faulting and aligning
// misalignment policy), each with its own word memory, checked against
// directed vectors and a byte-addressed reference model.
module tb_lsu_rmw;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_fault;
  logic [15:0] mem_address [2];
  logic [1:0]  mem_we;
  logic [31:0] mem_wd [2];
  logic [31:0] mem_rd [2];

  logic [31:0] mem [2][256];
  logic [7:0]  mb  [2][1024];

  int n_cmp;
  int n_fail;

  lsu_rmw #(.ADDR_W(16), .FAULT_ON_MISALIGN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
    .mem_address(mem_address[0]), .mem_we(mem_we[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0])
  );

  lsu_rmw #(.ADDR_W(16), .FAULT_ON_MISALIGN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
    .mem_address(mem_address[1]), .mem_we(mem_we[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memories: combinational read, write on the edge ending a mem_we cycle.
  assign mem_rd[0] = mem[0][mem_address[0][9:2]];
  assign mem_rd[1] = mem[1][mem_address[1][9:2]];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (mem_we[d]) mem[d][mem_address[d][9:2]] = mem_wd[d];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int sel, input int a);
    int b;
    b = a - (a % 4);
    return {mb[sel][b+3], mb[sel][b+2], mb[sel][b+1], mb[sel][b]};
  endfunction

  task automatic preload(input int sel, input logic [15:0] a, input logic [31:0] w);
    mem[sel][a[9:2]] = w;
    for (int i = 0; i < 4; i++) mb[sel][{a[9:2], 2'b00} + i] = w[8*i +: 8];
  endtask

  // Reference model over a byte-addressed memory image.
  task automatic model(input int sel, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [15:0] ad, input logic [31:0] wd,
                       output logic [31:0] e_rd, output logic e_flt, output int e_lat,
                       output int e_we, output logic [31:0] e_wd);
    int n;
    int ea;
    logic [31:0] v;
    n = 1 << sz;
    e_rd = 0; e_flt = 0; e_we = 0; e_wd = 0; e_lat = 1;
    if (sz == 2'b11 || (sel == 0 && (int'(ad) % n) != 0)) begin
      e_flt = 1;
      e_lat = 1;
    end else begin
      ea = int'(ad) - (int'(ad) % n);
      if (wr) begin
        for (int i = 0; i < n; i++) mb[sel][ea+i] = wd[8*i +: 8];
        e_we  = 1;
        e_lat = (n == 4) ? 2 : 3;
        e_wd  = mword(sel, ea);
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[sel][ea+i]) << (8*i));
        if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e_rd  = v;
        e_lat = 2;
      end
    end
  endtask

  // One request: starts and ends on a falling edge, DUT left in IDLE.
  task automatic run_txn(input int sel, input logic wr, input logic [1:0] sz, input logic un,
                         input logic [15:0] ad, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt, output int lat,
                         output int wes, output logic [31:0] wdo);
    bit done;
    req_write = wr; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wd;
    req_valid[sel] = 1'b1;
    check("ready_idle", 32'(req_ready[sel]), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    lat = 0; wes = 0; wdo = 0; rd = 0; flt = 0; done = 0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_we[sel]) begin
        wes++;
        wdo = mem_wd[sel];
      end
      if (resp_valid[sel]) begin
        rd   = resp_rdata[sel];
        flt  = resp_fault[sel];
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_timeout: got no resp_valid expected resp within 8 cycles");
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid[sel]), 32'd0);
    $display("txn dut%0d wr=%0d sz=%0d un=%0d addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d we=%0d",
             sel, wr, sz, un, ad, wd, rd, flt, lat, wes);
  endtask

  typedef struct {
    int          sel;
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic [15:0] ad;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_flt;
    int          e_lat;
    int          e_we;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(int sel, logic wr, logic [1:0] sz, logic un, logic [15:0] ad,
                              logic [31:0] wd, logic [31:0] e_rd, logic e_flt, int e_lat,
                              int e_we, logic [31:0] e_wd);
    vec_t v;
    v.sel = sel; v.wr = wr; v.sz = sz; v.un = un; v.ad = ad; v.wd = wd;
    v.e_rd = e_rd; v.e_flt = e_flt; v.e_lat = e_lat; v.e_we = e_we; v.e_wd = e_wd;
    return v;
  endfunction

  initial begin
    vec_t        vecs[14];
    logic [31:0] rd, wdo, m_rd, m_wd;
    logic        flt, m_flt;
    int          lat, wes, m_lat, m_we;
    int          sel;
    logic        wr, un;
    logic [1:0]  sz;
    logic [15:0] ad;
    logic [31:0] wd;

    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 2'b00; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;

    vecs[0]  = mk(0, 0, 2'b10, 0, 16'h0010, 32'h0,        32'h11223344, 0, 2, 0, 32'h0);
    vecs[1]  = mk(0, 1, 2'b10, 0, 16'h0014, 32'hCAFEBABE, 32'h0,        0, 2, 1, 32'hCAFEBABE);
    vecs[2]  = mk(0, 1, 2'b00, 0, 16'h0022, 32'h5A5A5A77, 32'h0,        0, 3, 1, 32'hAA77CCDD);
    vecs[3]  = mk(0, 1, 2'b01, 0, 16'h0020, 32'h00001234, 32'h0,        0, 3, 1, 32'hAA771234);
    vecs[4]  = mk(0, 0, 2'b00, 0, 16'h0032, 32'h0,        32'hFFFFFFFF, 0, 2, 0, 32'h0);
    vecs[5]  = mk(0, 0, 2'b00, 1, 16'h0033, 32'h0,        32'h00000080, 0, 2, 0, 32'h0);
    vecs[6]  = mk(0, 0, 2'b01, 0, 16'h0030, 32'h0,        32'h00007F01, 0, 2, 0, 32'h0);
    vecs[7]  = mk(0, 0, 2'b01, 0, 16'h0032, 32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h0);
    vecs[8]  = mk(0, 0, 2'b01, 0, 16'h0041, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[9]  = mk(0, 0, 2'b11, 0, 16'h0040, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[10] = mk(0, 1, 2'b11, 0, 16'h0040, 32'h12345678, 32'h0,        1, 1, 0, 32'h0);
    vecs[11] = mk(1, 0, 2'b01, 1, 16'h0041, 32'h0,        32'h00007766, 0, 2, 0, 32'h0);
    vecs[12] = mk(1, 0, 2'b10, 0, 16'h0043, 32'h0,        32'h99887766, 0, 2, 0, 32'h0);
    vecs[13] = mk(1, 1, 2'b01, 0, 16'h0047, 32'h0000BEEF, 32'h0,        0, 3, 1, 32'hBEEF0000);

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++) preload(d, 16'(w * 4), $urandom);
    preload(0, 16'h0010, 32'h11223344);
    preload(0, 16'h0014, 32'h00000000);
    preload(0, 16'h0020, 32'hAABBCCDD);
    preload(0, 16'h0030, 32'h80FF7F01);
    preload(1, 16'h0040, 32'h99887766);
    preload(1, 16'h0044, 32'h00000000);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(req_ready[d]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_mem_we", 32'(mem_we[d]), 32'd0);
      check("rst_mem_address", 32'(mem_address[d]), 32'd0);
      check("rst_resp_rdata", resp_rdata[d], 32'd0);
      check("rst_resp_fault", 32'(resp_fault[d]), 32'd0);
      check("rst_mem_wd", mem_wd[d], 32'd0);
    end
    rst_n = 1'b1;

    // Directed vectors
    for (int k = 0; k < 14; k++) begin
      model(vecs[k].sel, vecs[k].wr, vecs[k].sz, vecs[k].un, vecs[k].ad, vecs[k].wd,
            m_rd, m_flt, m_lat, m_we, m_wd);
      run_txn(vecs[k].sel, vecs[k].wr, vecs[k].sz, vecs[k].un, vecs[k].ad, vecs[k].wd,
              rd, flt, lat, wes, wdo);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].e_rd);
      check($sformatf("vec%0d_fault", k), 32'(flt), 32'(vecs[k].e_flt));
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].e_lat));
      check($sformatf("vec%0d_we_pulses", k), 32'(wes), 32'(vecs[k].e_we));
      if (vecs[k].e_we != 0) check($sformatf("vec%0d_mem_wd", k), wdo, vecs[k].e_wd);
    end
    check("mem_0014", mem[0][16'h0014 >> 2], 32'hCAFEBABE);
    check("mem_0020", mem[0][16'h0020 >> 2], 32'hAA771234);
    check("mem_0040_no_write", mem[0][16'h0040 >> 2], mword(0, 16'h0040));

    // Reset asserted during the WRITE of a sub-word store
    preload(0, 16'h0050, 32'h01020304);
    req_write = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 16'h0051; req_wdata = 32'h000000EE;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check("rmw_read_addr", 32'(mem_address[0]), 32'h0050);
    check("rmw_read_no_we", 32'(mem_we[0]), 32'd0);
    @(negedge clk);
    check("rmw_write_we", 32'(mem_we[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw_we_gated", 32'(mem_we[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rmw_rst_ready", 32'(req_ready[0]), 32'd1);
    check("rmw_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rmw_mem_unchanged", mem[0][16'h0050 >> 2], 32'h01020304);
    rst_n = 1'b1;
    run_txn(0, 0, 2'b10, 0, 16'h0050, 32'h0, rd, flt, lat, wes, wdo);
    check("post_rst_load", rd, 32'h01020304);
    check("post_rst_latency", 32'(lat), 32'd2);

    // Randomized traffic against the reference model
    for (int k = 0; k < 300; k++) begin
      sel = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      un  = 1'($urandom_range(0, 1));
      ad  = 16'($urandom_range(0, 1023));
      wd  = $urandom;
      model(sel, wr, sz, un, ad, wd, m_rd, m_flt, m_lat, m_we, m_wd);
      run_txn(sel, wr, sz, un, ad, wd, rd, flt, lat, wes, wdo);
      check("rnd_rdata", rd, m_rd);
      check("rnd_fault", 32'(flt), 32'(m_flt));
      check("rnd_latency", 32'(lat), 32'(m_lat));
      check("rnd_we_pulses", 32'(wes), 32'(m_we));
      if (m_we != 0) check("rnd_mem_wd", wdo, m_wd);
      check("rnd_mem_word", mem[sel][ad[9:2]], mword(sel, int'(ad)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store initiator that drives the memory subsystem's word interface (address, write-enable, write-data, read-data) on behalf of the core.
- Converts byte, halfword and word loads and stores into word-wide accesses.
- Sub-word stores are done as read-modify-write: read the word, merge the lanes, write it back. Load results are sign- or zero-extended.
- Sits between the core's execute stage and the memory block (MMU plus data, stack and MMIO memories).

Parameters:
- ADDR_W, 16, width of the byte address presented to memory.
- FAULT_ON_MISALIGN, 1. When 1, a misaligned access faults with no memory access. When 0, the low address bits are forced to alignment.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  high when in IDLE; a request is accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal (faults).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid; misaligned access or illegal size.
- mem_address  out  ADDR_W  word-aligned byte address, bits [1:0] = 00.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_address in the same cycle.

Behaviour:
- Memory timing is decided: read data is valid combinationally in the cycle the address is driven; a write commits on the clk edge that ends a cycle with mem_we = 1.
- States: IDLE, READ, WRITE, RESP. Encoding lives in the shared package.
- Reset (rst_n = 0 at an edge):
  - state goes to IDLE; all captured registers go to 0.
  - Outputs: req_ready = 1, resp_valid = 0, resp_fault = 0, resp_rdata = 0, mem_we = 0, mem_address = 0, mem_wd = 0.
  - mem_we is gated combinationally by rst_n, so reset asserted during WRITE suppresses that write.
- IDLE:
  - On accept, latch addr, size, write, unsigned and wdata.
  - Misaligned or illegal request (FAULT_ON_MISALIGN = 1) goes to RESP with the fault flag set.
  - Load, or sub-word store, goes to READ.
  - Word store goes to WRITE.
- READ:
  - Drive mem_address = {addr[ADDR_W-1:2], 2'b00}; capture mem_rd into a word register.
  - Load goes to RESP. Sub-word store goes to WRITE.
- WRITE:
  - mem_we = 1.
  - mem_wd = req_wdata for a word store; otherwise the captured word with the selected lanes replaced.
  - Lane replacement for a byte store: the byte lane at addr[1:0] takes wdata[7:0].
  - Lane replacement for a half store: half lane addr[1] takes wdata[15:0].
  - Next state is RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata and resp_fault are registered and held stable through this cycle. Next state is IDLE.
  - The response has no backpressure; the core must sample it.
- Latency from accept edge to resp_valid:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - fault: 1 cycle.
- Loads are little-endian:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - Extend to 32 bits per req_unsigned.
  - Word loads ignore req_unsigned.
- Alignment:
  - Half requires addr[0] = 0; word requires addr[1:0] = 00.
  - With FAULT_ON_MISALIGN = 0, the offending low bits are treated as 0 and no fault is raised.
- mem_we is 0 in every state other than WRITE. mem_address holds the latched word address in READ and WRITE, and 0 otherwise.
- req_ready = 0 outside IDLE. req_valid is ignored while busy; there is no queueing.
- A new request can be accepted in the cycle after RESP. Back-to-back accesses therefore incur a one-cycle IDLE bubble.

Decomposition:
- Package lsu_pkg holds:
  - state encoding (IDLE/READ/WRITE/RESP).
  - size codes SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10.
  - lane-mask function.
- One natural sub-module, lsu_lane, holds the combinational logic:
  - merge: old word, wdata, size, offset → merged word.
  - extract/extend: word, size, offset, unsigned → load data.
- The FSM and registers stay in lsu_rmw.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles → req_ready = 1, resp_valid = 0, mem_we = 0, mem_address = 0.
- Word path:
  - Preload word 0x0010 = 0x11223344.
  - Load word @0x0010 → resp_valid 2 cycles after accept, resp_rdata = 0x11223344.
  - Store word 0xCAFEBABE @0x0014 → exactly one mem_we pulse with mem_wd = 0xCAFEBABE.
- Sub-word store:
  - Memory 0x0020 = 0xAABBCCDD; store byte 0x5A5A5A77 @0x0022.
  - → READ then WRITE with mem_wd = 0xAA77CCDD; resp_valid 3 cycles after accept.
  - Follow with half store 0x1234 @0x0020 → memory word = 0xAA771234.
- Extension:
  - Memory 0x0030 = 0x80FF7F01.
  - Load byte signed @0x0032 → 0xFFFFFFFF.
  - Load byte unsigned @0x0033 → 0x00000080.
  - Load half signed @0x0030 → 0x00007F01.
  - Load half signed @0x0032 → 0xFFFF80FF.
- Faults:
  - Half load @0x0041 → resp_fault = 1 one cycle after accept, resp_rdata = 0, mem_we never asserted.
  - req_size = 11 → fault.
  - Repeat with FAULT_ON_MISALIGN = 0: half load @0x0041 reads the lane at 0x0040 with no fault.
- Reset mid-operation:
  - Sub-word store, pull rst_n low during WRITE → memory word unchanged, next cycle IDLE with req_ready = 1.
  - A subsequent load then completes normally.
